// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: merges the CPU instruction and data SRAM-like request
// channels onto one shared master port. The address phase is combinational.
// A grant lock holds a stalled request stable. An in-order 1-bit FIFO routes
// each response back to the requester that issued it.
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin unlocked selection
// instead of fixed data-over-inst priority).
module sram_bus_arbiter #(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = $clog2(MAX_OUTST) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_req,
  input  logic             inst_cache,
  input  logic [31:0]      inst_addr,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [31:0]      inst_rdata,
  input  logic             data_req,
  input  logic             data_cache,
  input  logic             data_wr,
  input  logic [3:0]       data_wstrb,
  input  logic [2:0]       data_size,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,
  output logic             m_req,
  output logic             m_cache,
  output logic             m_wr,
  output logic [3:0]       m_wstrb,
  output logic [2:0]       m_size,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  input  logic [31:0]      m_rdata,
  input  logic             m_addr_ok,
  input  logic             m_data_ok,
  output logic [CNT_W-1:0] outst_cnt,
  output logic             rsp_err
);

  localparam int PTR_W = $clog2(MAX_OUTST);

  logic                 r_lock_v;
  logic                 r_lock_sel;
  logic [MAX_OUTST-1:0] r_fifo;
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_rsp_err;
`ifdef ARB_ROUND_ROBIN_EN
  logic                 r_last_sel;
`endif

  logic w_sel;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_full  = (r_cnt == CNT_W'(MAX_OUTST));
  assign w_empty = (r_cnt == '0);
  assign w_head  = r_fifo[r_rptr];
  assign w_push  = m_req && m_addr_ok;
  assign w_pop   = m_data_ok && !w_empty;

  // Grant selection: a held lock wins, otherwise the arbitration policy
  always_comb begin
    w_sel = 1'b0;
    if (r_lock_v) begin
      w_sel = r_lock_sel;
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      if (data_req && inst_req) w_sel = !r_last_sel;
      else                      w_sel = data_req;
`else
      w_sel = data_req;
`endif
    end
  end

  // Master-side request mux; inst grants are forced to word-size reads
  always_comb begin
    m_req   = (w_sel ? data_req : inst_req) && !w_full;
    m_cache = inst_cache;
    m_wr    = 1'b0;
    m_wstrb = '0;
    m_size  = 3'd2;
    m_addr  = inst_addr;
    m_wdata = '0;
    if (w_sel) begin
      m_cache = data_cache;
      m_wr    = data_wr;
      m_wstrb = data_wstrb;
      m_size  = data_size;
      m_addr  = data_addr;
      m_wdata = data_wdata;
    end
  end

  // Address-accept and response routing back to the requesters
  always_comb begin
    inst_addr_ok = m_addr_ok && m_req && !w_sel;
    data_addr_ok = m_addr_ok && m_req &&  w_sel;
    inst_data_ok = w_pop && !w_head;
    data_data_ok = w_pop &&  w_head;
    inst_rdata   = m_rdata;
    data_rdata   = m_rdata;
    outst_cnt    = r_cnt;
    rsp_err      = r_rsp_err;
  end

  // Grant lock: freeze the selection while the master stalls the request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_v   <= 1'b0;
      r_lock_sel <= 1'b0;
    end else if (w_push) begin
      r_lock_v   <= 1'b0;
    end else if (m_req) begin
      r_lock_v   <= 1'b1;
      r_lock_sel <= w_sel;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember the last accepted requester for round-robin fairness
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_last_sel <= 1'b0;
    else if (w_push) r_last_sel <= w_sel;
  end
`endif

  // Tracking FIFO storage; contents are only read behind valid pointers
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= w_sel;
  end

  // Pointers, occupancy counter and sticky spurious-response flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (m_data_ok && w_empty) r_rsp_err <= 1'b1;
    end
  end

endmodule
